// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request, hopper and status signals of the change dispenser
interface change_dispenser_if #(
  parameter int CNT_W = 8
);
  logic             change_valid;
  logic [6:0]       change_amount;
  logic             change_ready;
  logic             coin_ack;
  logic             eject_quarter;
  logic             eject_dime;
  logic             eject_nickel;
  logic             refill;
  logic             done;
  logic [6:0]       shortfall;
  logic             fault;
  logic [CNT_W-1:0] quarter_count;
  logic [CNT_W-1:0] dime_count;
  logic [CNT_W-1:0] nickel_count;

  modport master (
    output change_valid, change_amount, coin_ack, refill,
    input  change_ready, eject_quarter, eject_dime, eject_nickel,
           done, shortfall, fault, quarter_count, dime_count, nickel_count
  );

  modport slave (
    input  change_valid, change_amount, coin_ack, refill,
    output change_ready, eject_quarter, eject_dime, eject_nickel,
           done, shortfall, fault, quarter_count, dime_count, nickel_count
  );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy, inventory-aware coin payout with per-coin drop acknowledge
module change_dispenser #(
  parameter int QUARTER_INIT = 20,
  parameter int DIME_INIT    = 20,
  parameter int NICKEL_INIT  = 20,
  parameter int CNT_W        = 8,
  parameter int ACK_TIMEOUT  = 16
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, FINISH} state_t;
  typedef enum logic [1:0] {COIN_Q, COIN_D, COIN_N} coin_t;

  state_t           state, state_next;
  coin_t            coin, coin_next;
  logic [6:0]       remaining;
  logic [6:0]       shortfall_q;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] q_cnt, d_cnt, n_cnt;
  logic             fault_q;
  logic             accept, do_refill, ack_hit, expire;
  logic             q_ok, d_ok, n_ok;
  logic [6:0]       coin_value;

  assign q_ok = (remaining >= 7'd25) && (q_cnt != '0);
  assign d_ok = (remaining >= 7'd10) && (d_cnt != '0);
  assign n_ok = (remaining >= 7'd5)  && (n_cnt != '0);

  always_comb begin
    case (coin)
      COIN_Q:  coin_value = 7'd25;
      COIN_D:  coin_value = 7'd10;
      default: coin_value = 7'd5;
    endcase
  end

  always_comb begin
    state_next = state;
    coin_next  = coin;
    accept     = 1'b0;
    do_refill  = 1'b0;
    ack_hit    = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.change_valid) begin
          accept     = 1'b1;
          state_next = SELECT;
        end else if (bus.refill) begin
          do_refill = 1'b1;
        end
      end
      SELECT: begin
        if (q_ok) begin
          coin_next  = COIN_Q;
          state_next = EJECT;
        end else if (d_ok) begin
          coin_next  = COIN_D;
          state_next = EJECT;
        end else if (n_ok) begin
          coin_next  = COIN_N;
          state_next = EJECT;
        end else begin
          state_next = FINISH;
        end
      end
      EJECT: state_next = WAIT_ACK;
      WAIT_ACK: begin
        // An ack arriving in the expiry cycle still counts as a dropped coin.
        if (bus.coin_ack) begin
          ack_hit    = 1'b1;
          state_next = SELECT;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          expire     = 1'b1;
          state_next = SELECT;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      coin        <= COIN_Q;
      remaining   <= '0;
      timer       <= '0;
      shortfall_q <= '0;
      fault_q     <= 1'b0;
      q_cnt       <= CNT_W'(QUARTER_INIT);
      d_cnt       <= CNT_W'(DIME_INIT);
      n_cnt       <= CNT_W'(NICKEL_INIT);
    end else begin
      state <= state_next;
      coin  <= coin_next;
      if (accept)
        remaining <= bus.change_amount;
      else if (ack_hit)
        remaining <= remaining - coin_value;
      if (state == EJECT)
        timer <= '0;
      else if (state == WAIT_ACK)
        timer <= timer + TW'(1);
      // Latched on entry to FINISH so the value is valid alongside done.
      if (state == SELECT && state_next == FINISH)
        shortfall_q <= remaining;
      if (do_refill) begin
        q_cnt   <= CNT_W'(QUARTER_INIT);
        d_cnt   <= CNT_W'(DIME_INIT);
        n_cnt   <= CNT_W'(NICKEL_INIT);
        fault_q <= 1'b0;
      end
      if (ack_hit) begin
        case (coin)
          COIN_Q:  q_cnt <= q_cnt - CNT_W'(1);
          COIN_D:  d_cnt <= d_cnt - CNT_W'(1);
          default: n_cnt <= n_cnt - CNT_W'(1);
        endcase
      end
      // A silent hopper is treated as empty so smaller coins get a chance.
      if (expire) begin
        fault_q <= 1'b1;
        case (coin)
          COIN_Q:  q_cnt <= '0;
          COIN_D:  d_cnt <= '0;
          default: n_cnt <= '0;
        endcase
      end
    end
  end

  assign bus.change_ready  = (state == IDLE);
  assign bus.eject_quarter = (state == EJECT) && (coin == COIN_Q);
  assign bus.eject_dime    = (state == EJECT) && (coin == COIN_D);
  assign bus.eject_nickel  = (state == EJECT) && (coin == COIN_N);
  assign bus.done          = (state == FINISH);
  assign bus.shortfall     = shortfall_q;
  assign bus.fault         = fault_q;
  assign bus.quarter_count = q_cnt;
  assign bus.dime_count    = d_cnt;
  assign bus.nickel_count  = n_cnt;
endmodule
